// File: rtl/stdcore_pkg.sv
// Shared types and constants for the stdcore stream checker: FSM states,
// LFSR tap masks, the default seed and the Fibonacci LFSR step function.
package stdcore_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FAIL = 2'd2
    } stdcore_state_e;

    // Tap masks: bit n set means register bit n feeds the XOR.
    localparam logic [15:0] LFSR_TAP_REF      = 16'hB400;
    localparam logic [15:0] LFSR_TAP_STL      = 16'hD008;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;
    localparam logic [15:0] LFSR_STL_SEED_XOR = 16'hFFFF;

    function automatic logic [15:0] lfsr_next(input logic [15:0] q, input logic [15:0] tap);
        return {q[14:0], ^(q & tap)};
    endfunction

endpackage

// File: rtl/stdcore_lfsr16.sv
// 16-bit Fibonacci LFSR with programmable tap mask, synchronous reseed and
// advance enable; asynchronous reset also loads the seed.
module stdcore_lfsr16
    import stdcore_pkg::*;
(
    input  logic        clk,
    input  logic        arst,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        adv,
    input  logic [15:0] tap,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic [15:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = seed;
        end else if (adv) begin
            q_d = lfsr_next(q_q, tap);
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            q_q <= seed;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/stdcore_stream_chk.sv
// Consumer-end checker for the stdcore valid/ready stream: compares accepted
// words with a seeded LFSR reference. Optional backpressure: STDCORE_STREAM_CHK_STALL_EN.
module stdcore_stream_chk
    import stdcore_pkg::*;
#(
    parameter int unsigned DW     = 8,
    parameter logic [15:0] SEED   = LFSR_SEED_DEFAULT,
    parameter logic [4:0]  RDY_TH = 5'd12
) (
    input  logic          clk,
    input  logic          arst,
    input  logic          en,
    input  logic          clr,
    input  logic [DW-1:0] c,
    input  logic          c_val,
    output logic          c_rdy,
    output logic          err,
    output logic [DW-1:0] err_data,
    output logic [DW-1:0] err_exp,
    output logic [31:0]   rx_cnt
);

    stdcore_state_e state_q, state_d;
    logic           err_q, err_d;
    logic [DW-1:0]  err_data_q, err_data_d;
    logic [DW-1:0]  err_exp_q, err_exp_d;
    logic [31:0]    rx_cnt_q, rx_cnt_d;

    logic [15:0]    ref_q;
    logic [DW-1:0]  exp_w;
    logic           ref_adv;
    logic           rdy;
    logic           xfer;
    logic           match;
    logic           unused_ref;

    stdcore_lfsr16 u_ref (
        .clk  (clk),
        .arst (arst),
        .load (clr),
        .seed (SEED),
        .adv  (ref_adv),
        .tap  (LFSR_TAP_REF),
        .q    (ref_q)
    );

    assign exp_w      = ref_q[DW-1:0];
    assign unused_ref = ^ref_q;

`ifdef STDCORE_STREAM_CHK_STALL_EN
    logic [15:0] stl_q;
    logic        unused_stl;

    stdcore_lfsr16 u_stl (
        .clk  (clk),
        .arst (arst),
        .load (clr),
        .seed (SEED ^ LFSR_STL_SEED_XOR),
        .adv  (state_q == RUN),
        .tap  (LFSR_TAP_STL),
        .q    (stl_q)
    );

    assign rdy        = (state_q == RUN) && ({1'b0, stl_q[3:0]} < RDY_TH);
    assign unused_stl = ^stl_q[15:4];
`else
    logic unused_th;

    assign rdy       = (state_q == RUN);
    assign unused_th = ^RDY_TH;
`endif

    assign xfer  = c_val && rdy;
    assign match = (c == exp_w);

    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        err_data_d = err_data_q;
        err_exp_d  = err_exp_q;
        rx_cnt_d   = rx_cnt_q;
        ref_adv    = 1'b0;
        if (clr) begin
            state_d    = IDLE;
            err_d      = 1'b0;
            err_data_d = '0;
            err_exp_d  = '0;
            rx_cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (en) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (xfer) begin
                        if (rx_cnt_q != '1) begin
                            rx_cnt_d = rx_cnt_q + 32'd1;
                        end
                        if (match) begin
                            ref_adv = 1'b1;
                        end else begin
                            err_d      = 1'b1;
                            err_data_d = c;
                            err_exp_d  = exp_w;
                        end
                    end
                    // A mismatch wins over a simultaneous disable.
                    if (xfer && !match) begin
                        state_d = FAIL;
                    end else if (!en) begin
                        state_d = IDLE;
                    end
                end
                FAIL: begin
                    state_d = FAIL;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q    <= IDLE;
            err_q      <= 1'b0;
            err_data_q <= '0;
            err_exp_q  <= '0;
            rx_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            err_data_q <= err_data_d;
            err_exp_q  <= err_exp_d;
            rx_cnt_q   <= rx_cnt_d;
        end
    end

    assign c_rdy    = rdy;
    assign err      = err_q;
    assign err_data = err_data_q;
    assign err_exp  = err_exp_q;
    assign rx_cnt   = rx_cnt_q;

endmodule

// File: tb/tb_stdcore_stream_chk.sv
// Scoreboard bench for stdcore_stream_chk: a driver issues the seeded LFSR
// stream and queues expectations; a negedge monitor checks each transfer.
module tb_stdcore_stream_chk;

    logic        clk = 1'b0;
    logic        arst, en, clr, c_val;
    logic [7:0]  c;
    logic        c_rdy, err;
    logic [7:0]  err_data, err_exp;
    logic [31:0] rx_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] cnt;
        logic        e;
        logic [7:0]  d;
        logic [7:0]  x;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mdl;
    int unsigned exp_cnt;
    int unsigned widx;
    logic        pend = 1'b0;
    logic [7:0]  hand [5] = '{8'hE1, 8'hC3, 8'h87, 8'h0F, 8'h1E};

    always #5 clk = ~clk;

    stdcore_stream_chk #(.DW(8), .SEED(16'hACE1), .RDY_TH(5'd16)) dut (
        .clk      (clk),
        .arst     (arst),
        .en       (en),
        .clr      (clr),
        .c        (c),
        .c_val    (c_val),
        .c_rdy    (c_rdy),
        .err      (err),
        .err_data (err_data),
        .err_exp  (err_exp),
        .rx_cnt   (rx_cnt)
    );

`ifdef STDCORE_STREAM_CHK_STALL_EN
    logic        rdy_s, err_s;
    logic [7:0]  err_data_s, err_exp_s;
    logic [31:0] rx_cnt_s;
    int          rdy_s_hits = 0;

    stdcore_stream_chk #(.DW(8), .SEED(16'hACE1), .RDY_TH(5'd0)) dut_s (
        .clk      (clk),
        .arst     (arst),
        .en       (en),
        .clr      (clr),
        .c        (c),
        .c_val    (c_val),
        .c_rdy    (rdy_s),
        .err      (err_s),
        .err_data (err_data_s),
        .err_exp  (err_exp_s),
        .rx_cnt   (rx_cnt_s)
    );

    always @(negedge clk) if (rdy_s !== 1'b0) rdy_s_hits++;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] nxt(input logic [15:0] r);
        return {r[14:0], r[15] ^ r[13] ^ r[12] ^ r[10]};
    endfunction

    task automatic restart_model();
        mdl     = 16'hACE1;
        exp_cnt = 0;
        widx    = 0;
    endtask

    // Monitor: a transfer seen at this negedge is checked at the next one.
    always @(negedge clk) begin
        exp_t e;
        if (pend) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_xfer: got transfer expected none, rx_cnt=%0d", rx_cnt);
            end else begin
                e = sb.pop_front();
                chk("rx_cnt", rx_cnt, e.cnt);
                chk("err", {31'd0, err}, {31'd0, e.e});
                chk("err_data", {24'd0, err_data}, {24'd0, e.d});
                chk("err_exp", {24'd0, err_exp}, {24'd0, e.x});
            end
        end
        pend = c_val && c_rdy && !clr && !arst;
    end

    task automatic send(input bit corrupt, input bit drop_en);
        logic [7:0]  w;
        exp_t        e;
        int unsigned n;
        w     = (widx < 5) ? hand[widx] : mdl[7:0];
        c     = corrupt ? 8'h00 : w;
        c_val = 1'b1;
        n     = 0;
        @(negedge clk);
        while (!c_rdy && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!c_rdy) begin
            checks++;
            errors++;
            $display("FAIL rdy_timeout: got c_rdy=0 expected 1 within 200 cycles");
            c_val = 1'b0;
            return;
        end
        exp_cnt++;
        e.cnt = exp_cnt;
        e.e   = corrupt;
        e.d   = 8'h00;
        e.x   = corrupt ? w : 8'h00;
        sb.push_back(e);
        if (drop_en) en = 1'b0;
        mdl = nxt(mdl);
        widx++;
        @(posedge clk);
        #1;
        c_val = 1'b0;
    endtask

    task automatic pulse_clr();
        @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        restart_model();
    endtask

    initial begin
        arst  = 1'b1;
        en    = 1'b0;
        clr   = 1'b0;
        c_val = 1'b0;
        c     = 8'h00;
        restart_model();
        repeat (3) @(posedge clk);
        #1 arst = 1'b0;
        chk("rst_c_rdy", {31'd0, c_rdy}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_err_data", {24'd0, err_data}, 32'd0);
        chk("rst_err_exp", {24'd0, err_exp}, 32'd0);
        chk("rst_rx_cnt", rx_cnt, 32'd0);

        // Long clean stream
        en = 1'b1;
        for (int i = 0; i < 1000; i++) send(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("rx_cnt_1000", rx_cnt, 32'd1000);
        chk("err_after_1000", {31'd0, err}, 32'd0);

        // Fifth word corrupted
        pulse_clr();
        for (int i = 0; i < 5; i++) send(i == 4, 1'b0);
        chk("fail_c_rdy", {31'd0, c_rdy}, 32'd0);
        chk("fail_err_exp", {24'd0, err_exp}, 32'h1E);
        en = 1'b0;
        repeat (3) @(negedge clk);
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("fail_sticky_rdy", {31'd0, c_rdy}, 32'd0);
            chk("fail_sticky_err", {31'd0, err}, 32'd1);
        end
        chk("fail_rx_cnt", rx_cnt, 32'd5);

        // Clear out of the failed state
        pulse_clr();
        chk("clr_err", {31'd0, err}, 32'd0);
        chk("clr_rx_cnt", rx_cnt, 32'd0);
        chk("clr_err_data", {24'd0, err_data}, 32'd0);
        chk("clr_err_exp", {24'd0, err_exp}, 32'd0);
        for (int i = 0; i < 20; i++) send(1'b0, 1'b0);

        // Disable coinciding with a transfer, then resume
        send(1'b0, 1'b1);
        chk("en_drop_c_rdy", {31'd0, c_rdy}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("idle_c_rdy", {31'd0, c_rdy}, 32'd0);
        end
        chk("en_drop_rx_cnt", rx_cnt, exp_cnt);
        en = 1'b1;
        for (int i = 0; i < 20; i++) send(1'b0, 1'b0);
        repeat (2) @(negedge clk);

        // Asynchronous reset with a word in flight
        begin
            int unsigned n = 0;
            do begin
                @(posedge clk);
                #1;
                n++;
            end while (!c_rdy && n < 200);
            chk("arst_pre_rdy", {31'd0, c_rdy}, 32'd1);
        end
        c     = mdl[7:0];
        c_val = 1'b1;
        #1 arst = 1'b1;
        #1;
        chk("arst_c_rdy", {31'd0, c_rdy}, 32'd0);
        chk("arst_rx_cnt", rx_cnt, 32'd0);
        chk("arst_err", {31'd0, err}, 32'd0);
        chk("arst_err_data", {24'd0, err_data}, 32'd0);
        chk("arst_err_exp", {24'd0, err_exp}, 32'd0);
        c_val = 1'b0;
        @(posedge clk);
        #1 arst = 1'b0;
        restart_model();
        for (int i = 0; i < 20; i++) send(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("final_rx_cnt", rx_cnt, 32'd20);
        chk("final_err", {31'd0, err}, 32'd0);
        chk("sb_empty", sb.size(), 32'd0);

`ifdef STDCORE_STREAM_CHK_STALL_EN
        chk("stall_th0_rdy_hits", rdy_s_hits, 32'd0);
        chk("stall_th0_rx_cnt", rx_cnt_s, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
